// File: rtl/chipinvaders_pkg.sv
// rtl/chipinvaders_pkg.sv - shared screen constants, scorer state type and score helper
package chipinvaders_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;

    typedef enum logic [1:0] {
        S_SCAN   = 2'd0,
        S_COMMIT = 2'd1,
        S_OVER   = 2'd2
    } cs_state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/alien_cell_locator.sv
// rtl/alien_cell_locator.sv - maps a raster position to the formation cell under it
module alien_cell_locator
    import chipinvaders_pkg::*;
#(
    parameter int NUM_ROWS        = 3,
    parameter int NUM_COLUMNS     = 5,
    parameter int ALIEN_SPACING_X = 64,
    parameter int ALIEN_SPACING_Y = 32,
    parameter int ROW_W           = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    parameter int COL_W           = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
    input  logic [COORD_W-1:0] hpos,
    input  logic [COORD_W-1:0] vpos,
    input  logic [COORD_W-1:0] formation_x,
    input  logic [COORD_W-1:0] formation_y,
    output logic [ROW_W-1:0]   row,
    output logic [COL_W-1:0]   col,
    output logic               in_grid
);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] col_full;
    logic [COORD_W-1:0] row_full;

    // Spacings are powers of two, so the cell index is a plain shift.
    assign dx       = hpos - formation_x;
    assign dy       = vpos - formation_y;
    assign col_full = dx >> $clog2(ALIEN_SPACING_X);
    assign row_full = dy >> $clog2(ALIEN_SPACING_Y);

    assign in_grid = (hpos >= formation_x) && (vpos >= formation_y) &&
                     (row_full < COORD_W'(NUM_ROWS)) && (col_full < COORD_W'(NUM_COLUMNS));

    assign row = row_full[ROW_W-1:0];
    assign col = col_full[COL_W-1:0];

endmodule

// File: rtl/collision_scorer.sv
// rtl/collision_scorer.sv - per-frame laser/cannon collision detection, scoring and lives
module collision_scorer
    import chipinvaders_pkg::*;
#(
    parameter int NUM_ROWS        = 3,
    parameter int NUM_COLUMNS     = 5,
    parameter int ALIEN_SPACING_X = 64,
    parameter int ALIEN_SPACING_Y = 32,
    parameter int POINTS_BASE     = 10,
    parameter int START_LIVES     = 3,
    parameter int COMMIT_LINE     = 480,
    localparam int ROW_W          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int COL_W          = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [COORD_W-1:0]              hpos,
    input  logic [COORD_W-1:0]              vpos,
    input  logic                            display_on,
    input  logic                            laser_gfx,
    input  logic                            laser_active,
    input  logic                            alien_pixel,
    input  logic                            cannon_gfx,
    input  logic [COORD_W-1:0]              formation_x,
    input  logic [COORD_W-1:0]              formation_y,
    input  logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
    output logic                            hit_alien,
    output logic                            kill_valid,
    output logic [ROW_W-1:0]                kill_row,
    output logic [COL_W-1:0]                kill_col,
    output logic                            cannon_hit,
    output logic [7:0]                      score,
    output logic [1:0]                      lives,
    output logic                            game_over
);

    cs_state_t        state_q, state_d;
    logic             hit_pend_q, hit_pend_d;
    logic             cannon_pend_q, cannon_pend_d;
    logic [ROW_W-1:0] hit_row_q, hit_row_d;
    logic [COL_W-1:0] hit_col_q, hit_col_d;
    logic             hit_alien_q, hit_alien_d;
    logic             kill_valid_q, kill_valid_d;
    logic [ROW_W-1:0] kill_row_q, kill_row_d;
    logic [COL_W-1:0] kill_col_q, kill_col_d;
    logic             cannon_hit_q, cannon_hit_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic             game_over_q, game_over_d;

    logic [ROW_W-1:0] cell_row;
    logic [COL_W-1:0] cell_col;
    logic             in_grid;
    logic             cell_alive;
    logic             laser_qual;
    logic             cannon_qual;
    logic             at_commit;
    logic [7:0]       row_points;

    alien_cell_locator #(
        .NUM_ROWS        (NUM_ROWS),
        .NUM_COLUMNS     (NUM_COLUMNS),
        .ALIEN_SPACING_X (ALIEN_SPACING_X),
        .ALIEN_SPACING_Y (ALIEN_SPACING_Y),
        .ROW_W           (ROW_W),
        .COL_W           (COL_W)
    ) u_locator (
        .hpos        (hpos),
        .vpos        (vpos),
        .formation_x (formation_x),
        .formation_y (formation_y),
        .row         (cell_row),
        .col         (cell_col),
        .in_grid     (in_grid)
    );

    // Decoded select keeps the alive lookup in range when the locator is outside the grid.
    always_comb begin
        cell_alive = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                if (cell_row == ROW_W'(r) && cell_col == COL_W'(c)) begin
                    cell_alive = alive_matrix[r*NUM_COLUMNS+c];
                end
            end
        end
    end

    assign laser_qual  = display_on & laser_gfx & laser_active & alien_pixel & in_grid & cell_alive;
    assign cannon_qual = display_on & alien_pixel & cannon_gfx;
    assign at_commit   = (vpos == COORD_W'(COMMIT_LINE)) && (hpos == '0);
    assign row_points  = 8'(POINTS_BASE * (NUM_ROWS - int'(hit_row_q)));

    always_comb begin
        state_d       = state_q;
        hit_pend_d    = hit_pend_q;
        cannon_pend_d = cannon_pend_q;
        hit_row_d     = hit_row_q;
        hit_col_d     = hit_col_q;
        hit_alien_d   = hit_alien_q;
        kill_valid_d  = kill_valid_q;
        kill_row_d    = kill_row_q;
        kill_col_d    = kill_col_q;
        cannon_hit_d  = cannon_hit_q;
        score_d       = score_q;
        lives_d       = lives_q;
        game_over_d   = game_over_q;

        unique case (state_q)
            S_SCAN: begin
                // The first qualifying pixel in raster order owns the frame's kill.
                if (laser_qual && !hit_pend_q) begin
                    hit_pend_d = 1'b1;
                    hit_row_d  = cell_row;
                    hit_col_d  = cell_col;
                end
                if (cannon_qual) begin
                    cannon_pend_d = 1'b1;
                end
                if (at_commit) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                hit_alien_d  = hit_pend_q;
                kill_valid_d = hit_pend_q;
                kill_row_d   = hit_row_q;
                kill_col_d   = hit_col_q;
                cannon_hit_d = cannon_pend_q;
                if (hit_pend_q) begin
                    score_d = sat_add8(score_q, row_points);
                end
                if (cannon_pend_q && lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        game_over_d = 1'b1;
                    end
                end
                hit_pend_d    = 1'b0;
                cannon_pend_d = 1'b0;
                hit_row_d     = '0;
                hit_col_d     = '0;
                state_d       = game_over_d ? S_OVER : S_SCAN;
            end
            S_OVER: begin
                if (at_commit) begin
                    hit_alien_d  = 1'b0;
                    kill_valid_d = 1'b0;
                    cannon_hit_d = 1'b0;
                end
            end
            default: state_d = S_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_SCAN;
            hit_pend_q    <= 1'b0;
            cannon_pend_q <= 1'b0;
            hit_row_q     <= '0;
            hit_col_q     <= '0;
            hit_alien_q   <= 1'b0;
            kill_valid_q  <= 1'b0;
            kill_row_q    <= '0;
            kill_col_q    <= '0;
            cannon_hit_q  <= 1'b0;
            score_q       <= 8'd0;
            lives_q       <= 2'(START_LIVES);
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hit_pend_q    <= hit_pend_d;
            cannon_pend_q <= cannon_pend_d;
            hit_row_q     <= hit_row_d;
            hit_col_q     <= hit_col_d;
            hit_alien_q   <= hit_alien_d;
            kill_valid_q  <= kill_valid_d;
            kill_row_q    <= kill_row_d;
            kill_col_q    <= kill_col_d;
            cannon_hit_q  <= cannon_hit_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            game_over_q   <= game_over_d;
        end
    end

    assign hit_alien  = hit_alien_q;
    assign kill_valid = kill_valid_q;
    assign kill_row   = kill_row_q;
    assign kill_col   = kill_col_q;
    assign cannon_hit = cannon_hit_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_collision_scorer.sv
// tb/tb_collision_scorer.sv - table, sequence and randomized checks of collision_scorer
module tb_collision_scorer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hpos = '0;
    logic [9:0]  vpos = '0;
    logic        display_on = 1'b0;
    logic        laser_gfx = 1'b0;
    logic        laser_active = 1'b0;
    logic        alien_pixel = 1'b0;
    logic        cannon_gfx = 1'b0;
    logic [9:0]  formation_x = '0;
    logic [9:0]  formation_y = '0;
    logic [14:0] alive_matrix = '0;
    logic        hit_alien;
    logic        kill_valid;
    logic [1:0]  kill_row;
    logic [2:0]  kill_col;
    logic        cannon_hit;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic        game_over;

    collision_scorer dut (
        .clk          (clk),
        .reset        (reset),
        .hpos         (hpos),
        .vpos         (vpos),
        .display_on   (display_on),
        .laser_gfx    (laser_gfx),
        .laser_active (laser_active),
        .alien_pixel  (alien_pixel),
        .cannon_gfx   (cannon_gfx),
        .formation_x  (formation_x),
        .formation_y  (formation_y),
        .alive_matrix (alive_matrix),
        .hit_alien    (hit_alien),
        .kill_valid   (kill_valid),
        .kill_row     (kill_row),
        .kill_col     (kill_col),
        .cannon_hit   (cannon_hit),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          h, v, fx, fy;
        bit          disp, lg, la, ap, cg;
        logic [14:0] alive;
    } pix_t;

    typedef struct {
        pix_t p;
        bit   e_hit;
        int   e_row, e_col, e_score;
        bit   e_cannon;
        int   e_lives;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference game state and per-frame pending hits
    int m_score, m_lives, m_row, m_col;
    bit m_over, m_pend, m_cpend;
    bit e_hit, e_cannon;
    int e_row, e_col;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pix_t mk(input int h, input int v, input int fx, input int fy,
                                input bit disp, input bit lg, input bit la, input bit ap,
                                input bit cg, input logic [14:0] alive);
        pix_t p;
        p.h = h; p.v = v; p.fx = fx; p.fy = fy;
        p.disp = disp; p.lg = lg; p.la = la; p.ap = ap; p.cg = cg;
        p.alive = alive;
        return p;
    endfunction

    task automatic idle_inputs();
        display_on = 0; laser_gfx = 0; laser_active = 0; alien_pixel = 0; cannon_gfx = 0;
    endtask

    task automatic model_reset();
        m_score = 0; m_lives = 3; m_over = 0;
        m_pend = 0; m_cpend = 0; m_row = 0; m_col = 0;
    endtask

    task automatic drive_pix(input pix_t p);
        int r, c;
        hpos = 10'(p.h); vpos = 10'(p.v);
        formation_x = 10'(p.fx); formation_y = 10'(p.fy);
        display_on = p.disp; laser_gfx = p.lg; laser_active = p.la;
        alien_pixel = p.ap; cannon_gfx = p.cg; alive_matrix = p.alive;
        tick();
        if (!m_over) begin
            if (p.disp && p.ap && p.cg) m_cpend = 1;
            if (p.disp && p.lg && p.la && p.ap && p.h >= p.fx && p.v >= p.fy && !m_pend) begin
                c = (p.h - p.fx) / 64;
                r = (p.v - p.fy) / 32;
                if (r < 3 && c < 5 && p.alive[r*5+c]) begin
                    m_pend = 1; m_row = r; m_col = c;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic commit_frame(input string tag);
        idle_inputs();
        hpos = 10'd0; vpos = 10'd480;
        tick();
        hpos = 10'd1;
        tick();
        if (m_over) begin
            e_hit = 0; e_cannon = 0;
        end else begin
            e_hit = m_pend; e_cannon = m_cpend;
            e_row = m_row; e_col = m_col;
            if (m_pend) m_score = (m_score + 10 * (3 - m_row) > 255) ? 255 : m_score + 10 * (3 - m_row);
            if (m_cpend && m_lives > 0) begin
                m_lives--;
                if (m_lives == 0) m_over = 1;
            end
        end
        m_pend = 0; m_cpend = 0;
        check({tag, " hit_alien"}, hit_alien, e_hit);
        check({tag, " kill_valid"}, kill_valid, e_hit);
        check({tag, " cannon_hit"}, cannon_hit, e_cannon);
        check({tag, " score"}, score, m_score);
        check({tag, " lives"}, lives, m_lives);
        check({tag, " game_over"}, game_over, m_over);
        if (e_hit) begin
            check({tag, " kill_row"}, kill_row, e_row);
            check({tag, " kill_col"}, kill_col, e_col);
        end
        hpos = 10'd2; vpos = 10'd481;
        tick();
        tick();
        check({tag, " hit_alien held"}, hit_alien, e_hit);
        hpos = 10'd0; vpos = 10'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        model_reset();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " score"}, score, 0);
        check({tag, " lives"}, lives, 3);
        check({tag, " game_over"}, game_over, 0);
        check({tag, " hit_alien"}, hit_alien, 0);
        check({tag, " kill_valid"}, kill_valid, 0);
        check({tag, " cannon_hit"}, cannon_hit, 0);
        check({tag, " kill_row"}, kill_row, 0);
        check({tag, " kill_col"}, kill_col, 0);
    endtask

    localparam logic [14:0] ALL = 15'h7FFF;
    localparam int NV = 10;
    vec_t vt[NV];

    initial begin
        vt[0] = '{mk(170, 85, 100, 50, 1, 1, 1, 1, 0, ALL), 1, 1, 1, 20, 0, 3};
        vt[1] = '{mk(170, 85, 100, 50, 1, 1, 1, 1, 0, 15'h7FBF), 0, 0, 0, 20, 0, 3};
        vt[2] = '{mk(170, 85, 100, 50, 1, 1, 0, 1, 0, ALL), 0, 0, 0, 20, 0, 3};
        vt[3] = '{mk(359, 115, 100, 50, 1, 1, 1, 1, 0, ALL), 1, 2, 4, 30, 0, 3};
        vt[4] = '{mk(99, 85, 100, 50, 1, 1, 1, 1, 0, ALL), 0, 0, 0, 30, 0, 3};
        vt[5] = '{mk(420, 85, 100, 50, 1, 1, 1, 1, 0, ALL), 0, 0, 0, 30, 0, 3};
        vt[6] = '{mk(170, 146, 100, 50, 1, 1, 1, 1, 0, ALL), 0, 0, 0, 30, 0, 3};
        vt[7] = '{mk(100, 50, 100, 50, 1, 1, 1, 1, 0, ALL), 1, 0, 0, 60, 0, 3};
        vt[8] = '{mk(100, 50, 100, 50, 0, 1, 1, 1, 1, ALL), 0, 0, 0, 60, 0, 3};
        vt[9] = '{mk(300, 300, 100, 50, 1, 0, 0, 1, 1, ALL), 0, 0, 0, 60, 1, 2};

        model_reset();
        do_reset();
        check_reset_state("reset");
        for (int f = 0; f < 3; f++) commit_frame("idle");
        check_reset_state("idle3");

        for (int i = 0; i < NV; i++) begin
            drive_pix(vt[i].p);
            commit_frame($sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl hit", i), hit_alien, vt[i].e_hit);
            if (vt[i].e_hit) begin
                check($sformatf("vec%0d tbl row", i), kill_row, vt[i].e_row);
                check($sformatf("vec%0d tbl col", i), kill_col, vt[i].e_col);
            end
            check($sformatf("vec%0d tbl score", i), score, vt[i].e_score);
            check($sformatf("vec%0d tbl cannon", i), cannon_hit, vt[i].e_cannon);
            check($sformatf("vec%0d tbl lives", i), lives, vt[i].e_lives);
        end

        // Two overlaps in one frame: raster-first cell wins
        do_reset();
        drive_pix(mk(100 + 128 + 5, 50 + 3, 100, 50, 1, 1, 1, 1, 0, ALL));
        drive_pix(mk(100 + 256 + 5, 50 + 64 + 3, 100, 50, 1, 1, 1, 1, 0, ALL));
        commit_frame("two");
        check("two row", kill_row, 0);
        check("two col", kill_col, 2);
        check("two score", score, 30);

        // Lives countdown, score still applied on the game-over commit, then frozen
        do_reset();
        for (int f = 0; f < 3; f++) begin
            drive_pix(mk(300, 300, 100, 50, 1, 0, 0, 1, 1, ALL));
            if (f == 2) drive_pix(mk(170, 85, 100, 50, 1, 1, 1, 1, 0, ALL));
            commit_frame($sformatf("life%0d", f));
            check($sformatf("life%0d lives", f), lives, 2 - f);
        end
        check("over flag", game_over, 1);
        check("over score", score, 20);
        drive_pix(mk(300, 300, 100, 50, 1, 0, 0, 1, 1, ALL));
        drive_pix(mk(100, 50, 100, 50, 1, 1, 1, 1, 0, ALL));
        commit_frame("frozen");
        check("frozen lives", lives, 0);
        check("frozen score", score, 20);
        check("frozen cannon", cannon_hit, 0);

        // Saturation at 255
        do_reset();
        for (int f = 0; f < 8; f++) begin
            drive_pix(mk(110, 60, 100, 50, 1, 1, 1, 1, 0, ALL));
            commit_frame("pre");
        end
        drive_pix(mk(110, 120, 100, 50, 1, 1, 1, 1, 0, ALL));
        commit_frame("pre250");
        check("score 250", score, 250);
        drive_pix(mk(110, 60, 100, 50, 1, 1, 1, 1, 0, ALL));
        commit_frame("sat1");
        check("sat 255", score, 255);
        drive_pix(mk(110, 60, 100, 50, 1, 1, 1, 1, 0, ALL));
        commit_frame("sat2");
        check("sat hold", score, 255);

        // Reset mid-frame discards the pending hit
        drive_pix(mk(170, 300, 100, 250, 1, 1, 1, 1, 1, ALL));
        do_reset();
        commit_frame("midrst");
        check("midrst score", score, 0);
        check("midrst lives", lives, 3);
        check("midrst hit", hit_alien, 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 80; f++) begin
            int np, fx, fy, h, v;
            if (f % 10 == 0) do_reset();
            fx = $urandom_range(0, 300);
            fy = $urandom_range(0, 300);
            np = $urandom_range(1, 6);
            for (int k = 0; k < np; k++) begin
                h = fx + $urandom_range(0, 340) - 10;
                v = fy + $urandom_range(0, 110) - 5;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                drive_pix(mk(h, v, fx, fy, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                             $urandom_range(0, 7) == 0, 15'($urandom)));
            end
            commit_frame($sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
